// File: rtl/product_accumulator_if.sv
// Handshake bundle between a product source, the accumulator and the result sink.
interface product_accumulator_if #(
  parameter int PROD_W = 64,
  parameter int ACC_W  = 64,
  parameter int CNT_W  = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [PROD_W-1:0] product;
  logic              in_last;
  logic              clear;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  acc_out;
  logic [CNT_W-1:0]  out_count;
  logic              out_overflow;

  modport master (
    output in_valid, product, in_last, clear, out_ready,
    input  in_ready, out_valid, acc_out, out_count, out_overflow
  );

  modport slave (
    input  in_valid, product, in_last, clear, out_ready,
    output in_ready, out_valid, acc_out, out_count, out_overflow
  );
endinterface

// File: rtl/product_accumulator.sv
// Saturating multiply-accumulate back end: sums signed products per in_last-delimited
// group and presents one registered result beat per group.
//
// state | meaning
// ACCUM | accepting product terms into the running sum
// HOLD  | final group result presented, waiting for out_ready
module product_accumulator #(
  parameter int PROD_W = 64,
  parameter int ACC_W  = 64,
  parameter int CNT_W  = 16
) (
  input logic                 clk,
  input logic                 rst,
  product_accumulator_if.slave bus
);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  state_t                    state, state_next;
  logic signed [ACC_W-1:0]   acc, acc_next;
  logic [CNT_W-1:0]          count, count_next;
  logic                      ovf, ovf_next;

  logic signed [PROD_W-1:0]  prod_s;
  logic signed [ACC_W:0]     sum_wide;
  logic signed [ACC_W-1:0]   sum_sat;
  logic                      sat_hit;
  logic                      in_ready;
  logic                      accept;

  assign prod_s   = bus.product;
  // Ready depends only on state, clear and rst so a source can never combinationally loop.
  assign in_ready = (state == ACCUM) && !rst && !bus.clear;
  assign accept   = bus.in_valid && in_ready;

  // One-bit-wider sum; disagreeing top two bits mean the ACC_W range was exceeded.
  always_comb begin
    sum_wide = (ACC_W+1)'(acc) + (ACC_W+1)'(prod_s);
    sum_sat  = sum_wide[ACC_W-1:0];
    sat_hit  = 1'b0;
    case ({sum_wide[ACC_W], sum_wide[ACC_W-1]})
      2'b01: begin
        sum_sat = ACC_MAX;
        sat_hit = 1'b1;
      end
      2'b10: begin
        sum_sat = ACC_MIN;
        sat_hit = 1'b1;
      end
      default: ;
    endcase
  end

  // Next-state and next-register values.
  always_comb begin
    state_next = state;
    acc_next   = acc;
    count_next = count;
    ovf_next   = ovf;
    case (state)
      ACCUM: begin
        if (bus.clear) begin
          acc_next   = '0;
          count_next = '0;
          ovf_next   = 1'b0;
        end else if (accept) begin
          acc_next   = sum_sat;
          count_next = (&count) ? count : count + CNT_W'(1);
          ovf_next   = ovf | sat_hit;
          if (bus.in_last) state_next = HOLD;
        end
      end
      HOLD: begin
        // clear is ignored here so a pending result is never lost.
        if (bus.out_ready) begin
          acc_next   = '0;
          count_next = '0;
          ovf_next   = 1'b0;
          state_next = ACCUM;
        end
      end
      default: state_next = ACCUM;
    endcase
  end

  // State and accumulator registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ACCUM;
      acc   <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_next;
      acc   <= acc_next;
      count <= count_next;
      ovf   <= ovf_next;
    end
  end

  assign bus.in_ready     = in_ready;
  assign bus.out_valid    = (state == HOLD);
  assign bus.acc_out      = acc;
  assign bus.out_count    = count;
  assign bus.out_overflow = ovf;

endmodule

// File: tb/tb_product_accumulator.sv
// Randomized and directed bench for product_accumulator against a queue-based group model.
module tb_product_accumulator;
  localparam int PROD_W = 64;
  localparam int ACC_W  = 64;
  localparam int CNT_W  = 16;
  localparam longint MAXV = 64'sh7FFF_FFFF_FFFF_FFFF;
  localparam longint MINV = 64'sh8000_0000_0000_0000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  product_accumulator_if #(.PROD_W(PROD_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) bus ();

  product_accumulator #(.PROD_W(PROD_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks   = 0;
  int failures = 0;
  longint grp[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%h exp=0x%h", tag, got, exp);
    end
  endtask

  // Group result from the rules: running sum clamped to the signed 64-bit range after each term.
  function automatic void model(output logic [63:0] sum, output logic ovf, output logic [15:0] cnt);
    longint s;
    logic signed [127:0] w;
    s   = 0;
    ovf = 1'b0;
    foreach (grp[i]) begin
      w = s;
      w = w + grp[i];
      if (w > MAXV) begin
        s = MAXV; ovf = 1'b1;
      end else if (w < MINV) begin
        s = MINV; ovf = 1'b1;
      end else begin
        s = longint'(w);
      end
    end
    sum = s;
    cnt = (grp.size() > 65535) ? 16'hFFFF : 16'(grp.size());
  endfunction

  function automatic longint rand_prod();
    longint v;
    case ($urandom_range(0, 3))
      0: v = {$urandom, $urandom};
      1: v = longint'($signed($urandom));
      2: v = $urandom_range(0, 1) ? MAXV : MINV;
      default: v = {$urandom_range(0, 1) ? 2'b01 : 2'b10, 30'($urandom), 32'($urandom)};
    endcase
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.clear     = 1'b0;
    bus.out_ready = 1'b0;
    bus.product   = '0;
  endtask

  // Offers one term and waits (bounded) until it is accepted.
  task automatic send(input longint p, input bit last);
    bit done;
    done = 1'b0;
    bus.in_valid = 1'b1;
    bus.product  = p;
    bus.in_last  = last;
    for (int i = 0; i < 50 && !done; i++) begin
      #1;
      if (bus.in_ready) begin
        grp.push_back(p);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) check("send_timeout", 64'd0, 64'd1);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.product  = {$urandom, $urandom};
  endtask

  // Called right after the edge that accepted in_last; holds off out_ready, then handshakes.
  task automatic expect_result(input string tag, input int hold, input bit junk);
    logic [63:0] es;
    logic        eo;
    logic [15:0] ec;
    model(es, eo, ec);
    check({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
    for (int i = 0; i <= hold; i++) begin
      if (junk) begin
        bus.in_valid = 1'b1;
        bus.product  = {$urandom, $urandom};
        bus.in_last  = 1'($urandom);
      end
      #1;
      check({tag, "_acc"}, bus.acc_out, es);
      check({tag, "_cnt"}, 64'(bus.out_count), 64'(ec));
      check({tag, "_ovf"}, 64'(bus.out_overflow), 64'(eo));
      check({tag, "_rdy_hold"}, 64'(bus.in_ready), 64'd0);
      if (i == hold) bus.out_ready = 1'b1;
      tick();
    end
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    #1;
    check({tag, "_drop"}, 64'(bus.out_valid), 64'd0);
    check({tag, "_zero"}, bus.acc_out, 64'd0);
    check({tag, "_rdy_after"}, 64'(bus.in_ready), 64'd1);
    grp.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    check("rst_ready", 64'(bus.in_ready), 64'd0);
    check("rst_valid", 64'(bus.out_valid), 64'd0);
    check("rst_acc", bus.acc_out, 64'd0);
    check("rst_cnt", 64'(bus.out_count), 64'd0);
    check("rst_ovf", 64'(bus.out_overflow), 64'd0);
    rst = 1'b0;
    #1;
    check("post_rst_ready", 64'(bus.in_ready), 64'd1);

    // Basic group with latency check.
    send(-64'sd51999143748, 1'b0);
    check("basic_no_valid_yet", 64'(bus.out_valid), 64'd0);
    send(64'sd110450657950, 1'b0 | 1'b1);
    check("basic_acc_const", bus.acc_out, 64'd58451514202);
    expect_result("basic", 0, 1'b0);

    // Backpressure with new data offered throughout.
    send(-64'sd51999143748, 1'b0);
    send(64'sd110450657950, 1'b1);
    expect_result("bp", 5, 1'b1);
    send(64'sd7, 1'b1);
    check("bp_next_acc", bus.acc_out, 64'd7);
    expect_result("bp_next", 0, 1'b0);

    // Positive saturation.
    send(64'sh4000_0000_0000_0000, 1'b0);
    send(64'sh4000_0000_0000_0000, 1'b0);
    send(64'sd5, 1'b1);
    check("psat_acc", bus.acc_out, 64'h7FFF_FFFF_FFFF_FFFF);
    check("psat_cnt", 64'(bus.out_count), 64'd3);
    check("psat_ovf", 64'(bus.out_overflow), 64'd1);
    expect_result("psat", 1, 1'b0);

    // Negative saturation, then the flag must not carry into the next group.
    send(MINV, 1'b0);
    send(-64'sd1, 1'b1);
    check("nsat_acc", bus.acc_out, 64'h8000_0000_0000_0000);
    check("nsat_ovf", 64'(bus.out_overflow), 64'd1);
    expect_result("nsat", 0, 1'b0);
    send(64'sd7, 1'b1);
    check("nsat_next_ovf", 64'(bus.out_overflow), 64'd0);
    expect_result("nsat_next", 0, 1'b0);

    // Clear aborts the group; the term offered alongside is refused.
    send(64'sd100, 1'b0);
    send(64'sd200, 1'b0);
    bus.in_valid = 1'b1;
    bus.product  = 64'sd999;
    bus.clear    = 1'b1;
    #1;
    check("clr_ready", 64'(bus.in_ready), 64'd0);
    tick();
    bus.clear    = 1'b0;
    bus.in_valid = 1'b0;
    grp.delete();
    check("clr_acc", bus.acc_out, 64'd0);
    check("clr_cnt", 64'(bus.out_count), 64'd0);
    send(-64'sd672, 1'b1);
    check("clr_res_acc", bus.acc_out, 64'hFFFF_FFFF_FFFF_FD60);
    check("clr_res_cnt", 64'(bus.out_count), 64'd1);
    // Clear while holding is ignored.
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    check("clr_hold_kept", bus.acc_out, 64'hFFFF_FFFF_FFFF_FD60);
    expect_result("clr", 0, 1'b0);

    // Reset while a result is pending.
    send(64'sd5, 1'b0);
    send(64'sd6, 1'b1);
    check("mrst_pending", 64'(bus.out_valid), 64'd1);
    rst = 1'b1;
    #1;
    check("mrst_ready_in_rst", 64'(bus.in_ready), 64'd0);
    tick();
    check("mrst_valid", 64'(bus.out_valid), 64'd0);
    check("mrst_acc", bus.acc_out, 64'd0);
    check("mrst_cnt", 64'(bus.out_count), 64'd0);
    check("mrst_ovf", 64'(bus.out_overflow), 64'd0);
    rst = 1'b0;
    grp.delete();
    #1;
    check("mrst_ready", 64'(bus.in_ready), 64'd1);
    send(64'sd12, 1'b1);
    check("mrst_acc12", bus.acc_out, 64'd12);
    expect_result("mrst", 0, 1'b0);

    // Randomized groups with gaps and random result backpressure.
    for (int g = 0; g < 40; g++) begin
      n = $urandom_range(1, 6);
      for (int t = 0; t < n; t++) begin
        repeat ($urandom_range(0, 2)) begin
          bus.in_valid = 1'b0;
          bus.product  = {$urandom, $urandom};
          tick();
        end
        send(rand_prod(), t == n - 1);
        if (t != n - 1) check("rnd_mid_valid", 64'(bus.out_valid), 64'd0);
      end
      expect_result("rnd", $urandom_range(0, 3), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
